// File: rtl/writeback_checker.sv
// writeback_checker
// -----------------
// Self-checking monitor for a register-file writeback port. Before a run,
// the host loads an ordered list of expected (register, value) writes into
// a circular queue. During the run, every qualifying writeback is compared
// against the queue head, which is then popped. The monitor counts
// mismatches, flags a stall when no write is consumed for TIMEOUT_CYCLES
// cycles, and reports pass/fail.
//
// Ports:
//   clock, ctrl_reset            - clock and synchronous active-high reset
//   exp_valid/exp_ready          - expected-entry load handshake
//   exp_reg, exp_data            - expected destination register and value
//   start                        - begin a run (single-cycle pulse)
//   clear                        - leave DONE, empty the queue, clear results
//   ctrl_writeEnable,
//   ctrl_writeReg, data_writeReg - monitored writeback port
//   busy, done                   - run in progress / run finished
//   pass, timeout                - final verdict and stall flag
//   error_count                  - saturating mismatch count for this run
//   mismatch_valid               - one-cycle pulse per mismatch
//   mismatch_index, mismatch_data- load-order index and observed data of the
//                                  latest mismatch
module writeback_checker #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 16,
    parameter int ERR_CNT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int IGNORE_R0      = 1,
    parameter int STOP_ON_ERROR  = 0
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    input  logic                      exp_valid,
    output logic                      exp_ready,
    input  logic [REG_ADDR_WIDTH-1:0] exp_reg,
    input  logic [DATA_WIDTH-1:0]     exp_data,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      ctrl_writeEnable,
    input  logic [REG_ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]     data_writeReg,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [ERR_CNT_WIDTH-1:0]  error_count,
    output logic                      mismatch_valid,
    output logic [$clog2(DEPTH):0]    mismatch_index,
    output logic [DATA_WIDTH-1:0]     mismatch_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [CNT_W-1:0]            cons_idx_q, cons_idx_d;
    logic [TMR_W-1:0]            timer_q, timer_d;
    logic [ERR_CNT_WIDTH-1:0]    error_count_q, error_count_d;
    logic                        timeout_q, timeout_d;
    logic                        pass_q, pass_d;
    logic                        mismatch_valid_q, mismatch_valid_d;
    logic [CNT_W-1:0]            mismatch_index_q, mismatch_index_d;
    logic [DATA_WIDTH-1:0]       mismatch_data_q, mismatch_data_d;

    // Expected-entry storage. Read asynchronously so the head is available
    // in the same cycle as the writeback it is compared against.
    logic [REG_ADDR_WIDTH-1:0]   reg_mem [DEPTH];
    logic [DATA_WIDTH-1:0]       data_mem [DEPTH];

    logic                        load_accept;
    logic                        qual_write;
    logic                        is_mismatch;
    logic [REG_ADDR_WIDTH-1:0]   head_reg;
    logic [DATA_WIDTH-1:0]       head_data;

    assign exp_ready   = (state_q == ST_IDLE) && (count_q < CNT_W'(DEPTH));
    assign load_accept = exp_valid && exp_ready;
    assign head_reg    = reg_mem[rd_ptr_q];
    assign head_data   = data_mem[rd_ptr_q];
    assign qual_write  = (state_q == ST_RUN) && ctrl_writeEnable &&
                         !((IGNORE_R0 != 0) && (ctrl_writeReg == '0));
    assign is_mismatch = (ctrl_writeReg != head_reg) || (data_writeReg != head_data);

    always_ff @(posedge clock) begin
        if (load_accept) begin
            reg_mem[wr_ptr_q]  <= exp_reg;
            data_mem[wr_ptr_q] <= exp_data;
        end
    end

    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        cons_idx_d       = cons_idx_q;
        timer_d          = timer_q;
        error_count_d    = error_count_q;
        timeout_d        = timeout_q;
        pass_d           = pass_q;
        mismatch_valid_d = 1'b0;
        mismatch_index_d = mismatch_index_q;
        mismatch_data_d  = mismatch_data_q;

        case (state_q)
            ST_IDLE: begin
                if (load_accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end
                if (start) begin
                    // A load accepted alongside start already counts toward
                    // the run, so check it as well as the stored count.
                    if ((count_q != '0) || load_accept) begin
                        state_d       = ST_RUN;
                        timer_d       = '0;
                        cons_idx_d    = '0;
                        error_count_d = '0;
                    end else begin
                        state_d   = ST_DONE;
                        pass_d    = 1'b1;
                        timeout_d = 1'b0;
                    end
                end
            end

            ST_RUN: begin
                if (qual_write) begin
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    count_d    = count_q - 1'b1;
                    cons_idx_d = cons_idx_q + 1'b1;
                    timer_d    = '0;
                    if (is_mismatch) begin
                        if (error_count_q != '1) begin
                            error_count_d = error_count_q + 1'b1;
                        end
                        mismatch_valid_d = 1'b1;
                        mismatch_index_d = cons_idx_q;
                        mismatch_data_d  = data_writeReg;
                    end
                    // Consuming the final entry ends the run even when the
                    // idle counter would have expired on this same edge.
                    if ((count_q == CNT_W'(1)) ||
                        (is_mismatch && (STOP_ON_ERROR != 0))) begin
                        state_d = ST_DONE;
                        pass_d  = (error_count_d == '0);
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timer_d   = TMR_W'(TIMEOUT_CYCLES);
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (clear) begin
                    state_d          = ST_IDLE;
                    wr_ptr_d         = '0;
                    rd_ptr_d         = '0;
                    count_d          = '0;
                    cons_idx_d       = '0;
                    timer_d          = '0;
                    error_count_d    = '0;
                    timeout_d        = 1'b0;
                    pass_d           = 1'b0;
                    mismatch_index_d = '0;
                    mismatch_data_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q          <= ST_IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            cons_idx_q       <= '0;
            timer_q          <= '0;
            error_count_q    <= '0;
            timeout_q        <= 1'b0;
            pass_q           <= 1'b0;
            mismatch_valid_q <= 1'b0;
            mismatch_index_q <= '0;
            mismatch_data_q  <= '0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            cons_idx_q       <= cons_idx_d;
            timer_q          <= timer_d;
            error_count_q    <= error_count_d;
            timeout_q        <= timeout_d;
            pass_q           <= pass_d;
            mismatch_valid_q <= mismatch_valid_d;
            mismatch_index_q <= mismatch_index_d;
            mismatch_data_q  <= mismatch_data_d;
        end
    end

    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign error_count    = error_count_q;
    assign mismatch_valid = mismatch_valid_q;
    assign mismatch_index = mismatch_index_q;
    assign mismatch_data  = mismatch_data_q;

endmodule

// File: doc/writeback_checker.md
Name: writeback_checker

Overview:
- Synthesizable, parametrised self-checking monitor for the processor register-file writeback port.
- Before a run, the bench or host loads an ordered list of expected (register, value) writes into an internal queue.
- During the run, it compares every qualifying writeback against the queue head, counts mismatches, detects stalls, and reports pass/fail.
- Replaces fixed-period polling checks with write-ordered, timeout-guarded checking.

Parameters:
DATA_WIDTH, 32, width of writeback data and expected values
REG_ADDR_WIDTH, 5, register index width
DEPTH, 16, expected-entry queue capacity (power of two, >=2)
ERR_CNT_WIDTH, 8, error counter width (saturating)
TIMEOUT_CYCLES, 64, max idle cycles between consumed writes during a run
IGNORE_R0, 1, 1 = writes to register 0 are not checked
STOP_ON_ERROR, 0, 1 = first mismatch ends the run

Ports:
clock  in  1  system clock
ctrl_reset  in  1  synchronous active-high reset
exp_valid  in  1  expected-entry load request
exp_ready  out  1  queue can accept an entry
exp_reg  in  REG_ADDR_WIDTH  expected destination register
exp_data  in  DATA_WIDTH  expected write value
start  in  1  begin run (single-cycle pulse)
clear  in  1  return from DONE to IDLE, empty queue, clear results
ctrl_writeEnable  in  1  monitored writeback enable
ctrl_writeReg  in  REG_ADDR_WIDTH  monitored writeback register
data_writeReg  in  DATA_WIDTH  monitored writeback data
busy  out  1  high in RUN
done  out  1  high in DONE
pass  out  1  valid when done: 1 = no errors and no timeout
timeout  out  1  run ended by stall
error_count  out  ERR_CNT_WIDTH  mismatches this run
mismatch_valid  out  1  one-cycle pulse per mismatch
mismatch_index  out  log2(DEPTH)+1  entry index (0-based load order) of latest mismatch
mismatch_data  out  DATA_WIDTH  observed data of latest mismatch

Behaviour:
- All state is updated on posedge clock. ctrl_reset takes priority over all inputs.
- Reset values: every output is 0, except exp_ready=1. Queue empty, state IDLE, counters 0.
- Reset mid-run aborts immediately. No done pulse. The queue is emptied.
- States:
  - IDLE -> RUN on start when queue non-empty.
  - IDLE -> DONE on start when queue empty; pass=1.
  - RUN -> DONE on last entry consumed, on timeout, or on the first mismatch when STOP_ON_ERROR=1.
  - DONE -> IDLE only on clear.
- Loading:
  - exp_ready = (state==IDLE) && count<DEPTH.
  - An entry is accepted on exp_valid && exp_ready.
  - When start and an accepted load occur in the same cycle, that entry is included in the run.
  - exp_valid outside IDLE or when full is ignored.
- Qualifying write: RUN && ctrl_writeEnable && !(IGNORE_R0 && ctrl_writeReg==0). Writes in IDLE or DONE are ignored.
- Each qualifying write pops the queue head.
  - Mismatch if ctrl_writeReg!=exp_reg or data_writeReg!=exp_data.
  - On mismatch, registered results appear after the same clock edge: error_count+1 (saturates at all-ones); mismatch_valid=1 for exactly one cycle; mismatch_index and mismatch_data are updated and held until the next mismatch or clear.
- Timeout counter:
  - Zeroed on entering RUN and on each qualifying write; otherwise increments in RUN.
  - When it reaches TIMEOUT_CYCLES, state goes to DONE with timeout=1 and pass=0.
  - If the final entry is consumed in the same cycle the counter reaches TIMEOUT_CYCLES, completion wins (timeout=0).
- DONE outputs:
  - done=1, busy=0.
  - pass = (error_count==0 && !timeout).
  - Remaining queue entries are discarded on clear.
- clear: allowed in any state, but acts only in DONE. Returns to IDLE, zeroes error_count, timeout, pass and the mismatch fields, and empties the queue.
- Queue:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - count has range 0..DEPTH.
  - Entry index is a run-relative consume counter, not the pointer value.

Test Plan:
- Load r1=5, r2=3, r3=8, r4=2; start; drive those four writes in order, one per cycle -> done=1, pass=1, error_count=0, no mismatch_valid pulses.
- Same load; third write is r3=9 (STOP_ON_ERROR=0) -> mismatch_valid pulse after the third write with mismatch_index=2 and mismatch_data=9; run completes after the fourth write; error_count=1, pass=0.
- STOP_ON_ERROR=1, same mismatch -> done=1 immediately after the third write; the fourth write is ignored; error_count=1.
- Load r1=20; start; drive writes r0=345, r0=567, then r1=20 -> r0 writes are not consumed; pass=1.
- Load 2 entries; start; supply one matching write, then no writes for 64 cycles -> timeout=1, pass=0, done=1. Assert clear -> IDLE, all results 0, exp_ready=1.
- Load 16 entries -> exp_ready=0 on the 17th exp_valid and that entry is dropped. Assert ctrl_reset mid-run after 5 writes -> busy=0, done=0, exp_ready=1, error_count=0 on the next cycle.
